// File: rtl/signed_mult_const_pipe.sv
// Pipelined per-channel signed multiply by constant with round-half-up; 3-cycle latency, global stall on !out_ready.
// Define SIGNED_MULT_CONST_SAT_EN to saturate into OUT_W bits and flag clipping; otherwise the result wraps.
module signed_mult_const_pipe #(
   parameter int N      = 8,
   parameter int CH     = 2,
   parameter int COEF   = 92681,
   parameter int COEF_W = 18,
   parameter int FRAC   = 16,
   parameter int OUT_W  = N + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH*N-1:0]       in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH*OUT_W-1:0]   out_data,
   output logic [CH-1:0]         out_ovf
);

   localparam int PW = N + COEF_W;
   localparam int RW = PW + 1;
   localparam logic signed [COEF_W-1:0] COEF_S = COEF_W'(COEF);
   localparam logic signed [RW-1:0]     HALF   = RW'(64'sd1 <<< (FRAC - 1));
   localparam logic signed [RW-1:0]     MAX_R  = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [RW-1:0]     MIN_R  = ~MAX_R;

   logic                 en;
   logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [CH*N-1:0]      d1_q, d1_d;
   logic [CH*PW-1:0]     p2_q, p2_d;
   logic [CH*OUT_W-1:0]  o3_q, o3_d;
   logic [CH-1:0]        f3_q, f3_d;

   logic signed [PW-1:0] prod   [CH];
   logic signed [RW-1:0] rnd    [CH];
   logic signed [RW-1:0] shr    [CH];
   logic [OUT_W-1:0]     narrow [CH];
   logic [CH-1:0]        clip;

   always_comb begin
      en = !v3_q || out_ready;
      clip = '0;
      for (int k = 0; k < CH; k++) begin
         prod[k] = PW'($signed(d1_q[k*N +: N])) * PW'(COEF_S);
         // One extra bit on the rounding add keeps the half-LSB bias from wrapping.
         rnd[k]  = RW'($signed(p2_q[k*PW +: PW])) + HALF;
         shr[k]  = rnd[k] >>> FRAC;
`ifdef SIGNED_MULT_CONST_SAT_EN
         if (shr[k] > MAX_R) begin
            narrow[k] = MAX_R[OUT_W-1:0];
            clip[k]   = 1'b1;
         end else if (shr[k] < MIN_R) begin
            narrow[k] = MIN_R[OUT_W-1:0];
            clip[k]   = 1'b1;
         end else begin
            narrow[k] = shr[k][OUT_W-1:0];
         end
`else
         narrow[k] = shr[k][OUT_W-1:0];
`endif
      end
   end

   always_comb begin
      v1_d = v1_q;
      v2_d = v2_q;
      v3_d = v3_q;
      d1_d = d1_q;
      p2_d = p2_q;
      o3_d = o3_q;
      f3_d = f3_q;
      if (en) begin
         v1_d = in_valid;
         v2_d = v1_q;
         v3_d = v2_q;
         d1_d = in_data;
         // Flags only ever accompany a valid beat.
         f3_d = v2_q ? clip : '0;
         for (int k = 0; k < CH; k++) begin
            p2_d[k*PW +: PW]       = prod[k];
            o3_d[k*OUT_W +: OUT_W] = narrow[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         d1_q <= '0;
         p2_q <= '0;
         o3_q <= '0;
         f3_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         d1_q <= d1_d;
         p2_q <= p2_d;
         o3_q <= o3_d;
         f3_q <= f3_d;
      end
   end

   // in_ready is a combinational path from out_ready.
   assign in_ready  = en;
   assign out_valid = v3_q;
   assign out_data  = o3_q;
   assign out_ovf   = f3_q;

endmodule

// File: tb/tb_signed_mult_const_pipe.sv
// Scoreboard bench for signed_mult_const_pipe: default-parameter instance plus a x3.0 coefficient instance for overflow.
module tb_signed_mult_const_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_data;
   logic [17:0] out_data;
   logic [1:0]  out_ovf;

   logic        in_valid2, in_ready2, out_valid2, out_ready2;
   logic [15:0] in_data2;
   logic [17:0] out_data2;
   logic [1:0]  out_ovf2;

   int tests  = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int d0;
      int d1;
      int ovf;
      int stamp;
      bit lat;
   } exp_t;
   exp_t sb[$];

   logic        hold_pend = 1'b0;
   logic [17:0] hold_dat  = '0;

   signed_mult_const_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
   );

   signed_mult_const_pipe #(.N(8), .CH(2), .COEF(196608), .COEF_W(19), .FRAC(16), .OUT_W(9)) dut_s (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_ovf(out_ovf2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: round-half-up of a*sqrt(2) at 16 fraction bits, narrowed to 9 bits.
   function automatic int model(input int a);
      longint r;
      r = ((longint'(a) * 92681) + 32768) >>> 16;
`ifdef SIGNED_MULT_CONST_SAT_EN
      if (r > 255) r = 255;
      else if (r < -256) r = -256;
`else
      r = ((r + 256) & 511) - 256;
`endif
      return int'(r);
   endfunction

   task automatic send(input int a0, input int a1, input int e0, input int e1, input bit lat);
      bit done;
      logic [7:0] b0, b1;
      done = 1'b0;
      b0 = a0[7:0];
      b1 = a1[7:0];
      in_valid = 1'b1;
      in_data  = {b1, b0};
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{d0: e0, d1: e1, ovf: 0, stamp: cyc, lat: lat});
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sb.size() > 0) check("drain_left", sb.size(), 0);
      idle(5);
   endtask

   task automatic stream(input int cnt, input bit lat);
      int a0, a1;
      for (int i = 0; i < cnt; i++) begin
         a0 = int'($urandom_range(0, 255)) - 128;
         a1 = int'($urandom_range(0, 255)) - 128;
         send(a0, a1, model(a0), model(a1), lat);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (!out_valid) check("ovf_idle", int'(out_ovf), 0);
         if (hold_pend) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_data", int'(out_data), int'(hold_dat));
         end
         hold_pend = out_valid && !out_ready;
         hold_dat  = out_data;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               e = sb.pop_front();
               check("ch0", $signed(out_data[8:0]), e.d0);
               check("ch1", $signed(out_data[17:9]), e.d1);
               check("ovf", int'(out_ovf), e.ovf);
               if (e.lat) check("latency", cyc - e.stamp, 3);
            end
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit seen;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      in_valid2 = 1'b0;
      in_data2 = '0;
      out_ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", int'(out_valid), 0);
      check("reset_data", int'(out_data), 0);
      check("reset_ovf", int'(out_ovf), 0);
      rst = 1'b0;
      idle(2);
      check("idle_in_ready", int'(in_ready), 1);

      // Directed values with bubbles between them.
      send(100, -128, 141, -181, 1'b1);
      idle(1);
      send(127, 0, 180, 0, 1'b1);
      idle(1);
      send(-1, 0, -1, 0, 1'b1);
      idle(1);
      send(-128, 127, -181, 180, 1'b1);
      drain();

      // Back-to-back streaming: 10 outputs on 10 consecutive cycles.
      stream(10, 1'b1);
      drain();

      // Stall for 4 cycles in the middle of a stream.
      fork
         stream(10, 1'b0);
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("in_ready_stall", int'(in_ready), 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with beats in flight.
      send(10, 20, model(10), model(20), 1'b0);
      send(-30, 40, model(-30), model(40), 1'b0);
      send(50, -60, model(50), model(-60), 1'b0);
      check("pre_rst_valid", int'(out_valid), 1);
      rst = 1'b1;
      #1;
      check("rst_async_valid", int'(out_valid), 0);
      check("rst_async_data", int'(out_data), 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(6);
      check("post_rst_empty", int'(out_valid), 0);
      send(-100, 99, model(-100), model(99), 1'b1);
      drain();

      // Overflow instance: 127*3 and -128*3 exceed 9 bits.
      in_data2 = 16'h807F;
      in_valid2 = 1'b1;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      seen = 1'b0;
      n = 1;
      while (!seen && n < 10) begin
         if (out_valid2) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      check("sat_seen", int'(seen), 1);
      check("sat_latency", n, 3);
`ifdef SIGNED_MULT_CONST_SAT_EN
      check("sat_ch0", $signed(out_data2[8:0]), 255);
      check("sat_ch1", $signed(out_data2[17:9]), -256);
      check("sat_ovf", int'(out_ovf2), 3);
`else
      check("wrap_ch0", $signed(out_data2[8:0]), -131);
      check("wrap_ch1", $signed(out_data2[17:9]), 128);
      check("wrap_ovf", int'(out_ovf2), 0);
`endif
      @(posedge clk);
      #1;
      check("sat_bubble_valid", int'(out_valid2), 0);
      check("sat_bubble_ovf", int'(out_ovf2), 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
